// File: rtl/store_buffer_pkg.sv
// Store buffer shared types and defaults.
// Entry layout and word-index helper.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_IDX_W = 12;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic [29:0] word_of(
    input logic [31:0] a
  );
    return a[31:2];
  endfunction

endpackage

// File: rtl/sb_match.sv
// Load-vs-buffered-store word conflict detector.
// One comparator per slot, gated by valid, OR-reduced.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDX_W = SB_IDX_W
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][IDX_W-1:0] idx,
  input  logic [IDX_W-1:0]            ld_idx,
  output logic                        hit
);

  logic [DEPTH-1:0] eq;

  // per-slot compare against the load word index
  always_comb begin
    eq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eq[i] = valid[i] && (idx[i] == ld_idx);
    end
  end

  assign hit = |eq;

endmodule

// File: rtl/store_buffer.sv
// CPU store buffer: FIFO of pending stores drained to DM.
// Head drives DM combinationally; loads check word conflicts.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDX_W = SB_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_pc,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  input  logic                     dm_ready,
  output logic                     dm_we,
  output logic [31:0]              dm_pc,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_data,
  output logic [3:0]               dm_be,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t                   mem [DEPTH];
  sb_entry_t                   head;
  sb_entry_t                   wr_ent;
  logic [DEPTH-1:0]            valid;
  logic [PW-1:0]               wptr;
  logic [PW-1:0]               rptr;
  logic [CW-1:0]               cnt;
  logic                        push;
  logic                        pop;
  logic [DEPTH-1:0][IDX_W-1:0] ent_idx;
  logic [IDX_W-1:0]            ld_idx;
  logic [29:0]                 ld_word;
  logic                        unused_ld;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  assign head    = mem[rptr];
  assign dm_we   = !empty;
  assign dm_pc   = head.pc;
  assign dm_addr = head.addr;
  assign dm_data = head.data;
  assign dm_be   = head.be;

  assign pop      = dm_we && dm_ready;
  assign st_ready = !full || pop;
  // zero byte-enable stores are accepted but never buffered
  assign push     = st_valid && st_ready && (st_be != 4'h0);

  assign wr_ent = '{
    pc:   st_pc,
    addr: st_addr,
    data: st_data,
    be:   st_be
  };

  // payload storage; pointers and valid bits gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_ent;
    end
  end

  // pointers, occupancy and slot valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        rptr        <= rptr + 1'b1;
        valid[rptr] <= 1'b0;
      end
      if (push) begin
        wptr        <= wptr + 1'b1;
        valid[wptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign ld_word   = word_of(ld_addr);
  assign ld_idx    = ld_word[IDX_W-1:0];
  assign unused_ld = ^{ld_addr[1:0], ld_word};

  // word index of every slot for the conflict check
  always_comb begin
    ent_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_idx[i] = mem[i].addr[IDX_W+1:2];
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match (
    .valid  (valid),
    .idx    (ent_idx),
    .ld_idx (ld_idx),
    .hit    (ld_conflict)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change off-edge; outputs sampled near negedge.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_pc, st_addr, st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_pc, dm_addr, dm_data;
  logic [3:0]  dm_be;
  logic        empty, full;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_pc       (st_pc),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_be       (st_be),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict),
    .dm_ready    (dm_ready),
    .dm_we       (dm_we),
    .dm_pc       (dm_pc),
    .dm_addr     (dm_addr),
    .dm_data     (dm_data),
    .dm_be       (dm_be),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    st_valid = 1'b1;
    st_pc = pc; st_addr = a; st_data = d; st_be = be;
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    dm_ready = 1'b1;
    while (!empty && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    dm_ready = 1'b0;
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain_timeout empty=%0b want 1", empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    st_valid = 0; st_pc = 0; st_addr = 0; st_data = 0; st_be = 0;
    ld_addr = 0; dm_ready = 0;
    #12;
    checks++;
    if ({empty, full, count, dm_we, ld_conflict} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state e=%0b f=%0b c=%0d we=%0b lc=%0b want 1 0 0 0 0",
               empty, full, count, dm_we, ld_conflict);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", st_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    dm_ready = 1'b1;
    st_valid = 1'b1;
    st_pc = 32'h3000; st_addr = 32'h10; st_data = 32'hDEADBEEF; st_be = 4'hF;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass dm_we=%0b want 0", dm_we);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dm_we, dm_pc, dm_addr, dm_data, dm_be} !==
        {1'b1, 32'h3000, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++;
      $display("FAIL single_head we=%0b pc=%h a=%h d=%h be=%h want 1 3000 10 deadbeef f",
               dm_we, dm_pc, dm_addr, dm_data, dm_be);
    end
    @(negedge clk);
    checks++;
    if ({empty, dm_we} !== 2'b10) begin
      errors++;
      $display("FAIL single_empty empty=%0b we=%0b want 1 0", empty, dm_we);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++)
      push_one(32'h4000 + 4 * i, 32'h100 + 4 * i, 32'hA0 + i, 4'hF);
    @(negedge clk);
    st_valid = 1'b1;
    st_pc = 32'h5000; st_addr = 32'h200; st_data = 32'h55; st_be = 4'hF;
    #1;
    checks++;
    if ({full, st_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL fill_full f=%0b rdy=%0b c=%0d want 1 0 4", full, st_ready, count);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, dm_addr} !== {3'd4, 32'h100}) begin
      errors++;
      $display("FAIL fill_ignored c=%0d head=%h want 4 100", count, dm_addr);
    end
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({dm_we, dm_pc, dm_addr, dm_data} !==
          {1'b1, 32'h4000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
        errors++;
        $display("FAIL drain_order[%0d] we=%0b pc=%h a=%h d=%h", i, dm_we, dm_pc, dm_addr, dm_data);
      end
      @(negedge clk);
    end
    checks++;
    if ({empty, count, dm_we} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL drain_done e=%0b c=%0d we=%0b want 1 0 0", empty, count, dm_we);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_a [4];
    exp_a = '{32'h304, 32'h308, 32'h30C, 32'h3F0};
    for (int i = 0; i < 4; i++)
      push_one(32'h6000, 32'h300 + 4 * i, 32'h600 + i, 4'h3);
    @(negedge clk);
    st_valid = 1'b1;
    st_pc = 32'h6FF0; st_addr = 32'h3F0; st_data = 32'h6FF; st_be = 4'hC;
    dm_ready = 1'b1;
    #1;
    checks++;
    if ({full, st_ready} !== 2'b11) begin
      errors++;
      $display("FAIL pp_ready f=%0b rdy=%0b want 1 1", full, st_ready);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
    dm_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, full, dm_addr} !== {3'd4, 1'b1, 32'h304}) begin
      errors++;
      $display("FAIL pp_count c=%0d f=%0b head=%h want 4 1 304", count, full, dm_addr);
    end
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dm_addr !== exp_a[i]) begin
        errors++;
        $display("FAIL pp_order[%0d] got %h want %h", i, dm_addr, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (dm_be !== 4'hC && empty !== 1'b1) begin
      errors++;
      $display("FAIL pp_end be=%h empty=%0b", dm_be, empty);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_conflict();
    push_one(32'h7000, 32'h24, 32'h1, 4'hF);
    @(negedge clk);
    ld_addr = 32'h27;
    #1;
    checks++;
    if (ld_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_same_word got %0b want 1", ld_conflict);
    end
    ld_addr = 32'h28;
    #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      errors++;
      $display("FAIL conf_next_word got %0b want 0", ld_conflict);
    end
    ld_addr = 32'h4024;
    #1;
    checks++;
    if (ld_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_alias_high got %0b want 1", ld_conflict);
    end
    ld_addr = 32'h1024;
    #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      errors++;
      $display("FAIL conf_top_idx_bit got %0b want 0", ld_conflict);
    end
    ld_addr = 32'h24;
    dm_ready = 1'b1;
    #1;
    checks++;
    if (ld_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_popping got %0b want 1", ld_conflict);
    end
    @(negedge clk);
    dm_ready = 1'b0;
    checks++;
    if ({empty, ld_conflict} !== 2'b10) begin
      errors++;
      $display("FAIL conf_after_pop e=%0b lc=%0b want 1 0", empty, ld_conflict);
    end
    st_valid = 1'b1;
    st_pc = 32'h7004; st_addr = 32'h28; st_data = 32'h2; st_be = 4'h1;
    ld_addr = 32'h28;
    #1;
    checks++;
    if (ld_conflict !== 1'b0) begin
      errors++;
      $display("FAIL conf_push_excl got %0b want 0", ld_conflict);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_after_push got %0b want 1", ld_conflict);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      push_one(32'h8000, 32'h80 + 4 * i, 32'h800 + i, 4'hF);
    @(negedge clk);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre count got %0d want 3", count);
    end
    dm_ready = 1'b1;
    ld_addr = 32'h80;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({empty, count, dm_we, ld_conflict} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid e=%0b c=%0d we=%0b lc=%0b want 1 0 0 0",
               empty, count, dm_we, ld_conflict);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({dm_we, st_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rst_stale[%0d] we=%0b rdy=%0b want 0 1", i, dm_we, st_ready);
      end
      @(negedge clk);
    end
    dm_ready = 1'b0;
  endtask

  task automatic test_be_zero();
    @(negedge clk);
    st_valid = 1'b1;
    st_pc = 32'h9000; st_addr = 32'h90; st_data = 32'h9; st_be = 4'h0;
    #1;
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL bez_ready got %0b want 1", st_ready);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, dm_we, empty} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bez_nopush c=%0d we=%0b e=%0b want 0 0 1", count, dm_we, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_conflict();
    test_reset_mid();
    test_be_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter IDX_W, default 12, meaning word-index width compared for conflicts (addr[IDX_W+1:2]).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port st_valid  input  1  CPU store request.
REQ-006 SHALL have port st_ready  output  1  store accepted this cycle when high with st_valid.
REQ-007 SHALL have ports st_pc, st_addr, st_data  input  32 each  store PC, byte address, write data.
REQ-008 SHALL have port st_be  input  4  byte enables.
REQ-009 SHALL have port ld_addr  input  32  address of the load in the current cycle.
REQ-010 SHALL have port ld_conflict  output  1  a buffered store targets ld_addr's word.
REQ-011 SHALL have port dm_ready  input  1  DM can take a write this cycle.
REQ-012 SHALL have port dm_we  output  1  DM write strobe.
REQ-013 SHALL have ports dm_pc, dm_addr, dm_data  output  32 each; dm_be  output  4.
REQ-014 SHALL have ports empty, full  output  1 each; count  output  $clog2(DEPTH)+1.

Function
REQ-015 SHALL hold entries {pc, addr, data, be} in FIFO order, read and write pointers wrapping modulo DEPTH.
REQ-016 SHALL present the head entry combinationally on dm_pc/dm_addr/dm_data/dm_be; dm_we = !empty.
REQ-017 SHALL pop the head on a rising edge where dm_we && dm_ready.
REQ-018 SHALL push on a rising edge where st_valid && st_ready; entry visible at head no earlier than the next cycle (push-to-dm_we latency 1 cycle when empty).
REQ-019 SHALL drive st_ready = !full || (dm_we && dm_ready); a push and a pop in the same cycle while full SHALL both occur, count unchanged.
REQ-020 SHALL update count by +1 push-only, -1 pop-only, 0 for both or neither; full = (count == DEPTH), empty = (count == 0).
REQ-021 SHALL never pop when empty nor push when st_ready is low; st_valid while not ready SHALL be ignored (no state change).
REQ-022 SHALL assert ld_conflict combinationally when any valid entry, including one being popped this cycle, has addr[IDX_W+1:2] == ld_addr[IDX_W+1:2]; the entry being pushed this cycle is excluded.
REQ-023 SHALL ignore st_be == 0 stores (st_ready behaviour unchanged, no entry written).
REQ-024 SHALL keep entry payload registers without reset; only pointers/count/valid bits reset.

Reset
REQ-025 SHALL, on reset low, asynchronously clear pointers, count and valid bits: empty=1, full=0, count=0, dm_we=0, ld_conflict=0, st_ready=1 after release.
REQ-026 SHALL discard all buffered stores if reset asserts mid-drain; no dm_we pulse SHALL follow reset assertion until a new push.

Structure
REQ-027 SHALL place the sb_entry_t struct (pc, addr, data, be) and DEPTH/IDX_W defaults in package store_buffer_pkg.
REQ-028 SHALL use one sub-module sb_match (DEPTH parallel word-index comparators ANDed with valid, OR-reduced) for ld_conflict.

Verification
REQ-029 Empty, push {pc=0x3000, addr=0x10, data=0xDEADBEEF, be=0xF}, dm_ready=1 -> dm_we high next cycle with those values, empty again the cycle after.
REQ-030 dm_ready=0, push 4 stores -> full=1, st_ready=0, fifth st_valid ignored; raise dm_ready -> drained in push order over 4 cycles.
REQ-031 Full, st_valid=1 and dm_ready=1 same cycle -> push and pop both occur, count stays 4, new entry last out.
REQ-032 Buffered store addr=0x24, ld_addr=0x27 -> ld_conflict=1; ld_addr=0x28 -> 0; same-cycle push to 0x28 with ld_addr=0x28 and empty buffer -> 0.
REQ-033 Three entries buffered, reset pulsed low mid-cycle -> empty=1, count=0, dm_we=0 immediately, no stale writes after release.
REQ-034 Push with be=0 -> count unchanged, no dm_we.
